// File: rtl/codec_write_scheduler.sv
// Round-robin scheduler sharing one codec I2C write engine between N_REQ register writers.
// Builds the 24-bit frame, retries on NACK, aborts on engine timeout, enforces an inter-frame gap.
module codec_write_scheduler #(
  parameter int unsigned N_REQ          = 2,
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_done,
  output logic [N_REQ-1:0]      req_err,
  output logic                  wr_start,
  output logic [23:0]           wr_frame,
  input  logic                  wr_done,
  input  logic                  wr_nack,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

  // Abort at the edge that closes the TIMEOUT_CYCLES-th cycle counted from wr_start.
  localparam logic [TW-1:0] TimerLimit = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [GW-1:0] GapLast    = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    RetryMax   = 3'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [2:0]        retry_q, retry_d;
  logic              pend_q, pend_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [23:0]       frame_q, frame_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;

  logic [15:0]       req_slot [N_REQ];
  logic              found;
  logic [IW-1:0]     grant_idx;
  logic              fail;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_slot[i] = req_data[16*i +: 16];
    end
  end

  // Search rr+1, rr+2, ... so the most recently served requester has lowest priority.
  always_comb begin
    int unsigned idx;
    logic [IW-1:0] cand;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx  = (32'(rr_q) + k) % N_REQ;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    retry_d   = retry_q;
    pend_d    = pend_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    frame_d   = frame_q;
    err_cnt_d = err_cnt_q;
    done_d    = '0;
    err_d     = '0;
    fail      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = grant_idx;
          frame_d = {DEV_ADDR, req_slot[grant_idx]};
          retry_d = '0;
          pend_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wr_done) begin
          gap_d   = '0;
          state_d = StGap;
          if (!wr_nack) begin
            done_d[grant_q] = 1'b1;
            rr_d            = grant_q;
            pend_d          = 1'b0;
          end else if (retry_q < RetryMax) begin
            retry_d = retry_q + 3'd1;
            pend_d  = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (timer_q == TimerLimit) begin
          fail    = 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = pend_q ? StIssue : StIdle;
          pend_d  = 1'b0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (fail) begin
      done_d[grant_q] = 1'b1;
      err_d[grant_q]  = 1'b1;
      rr_d            = grant_q;
      pend_d          = 1'b0;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_q      <= IW'(N_REQ - 1);
      retry_q   <= '0;
      pend_q    <= 1'b0;
      timer_q   <= '0;
      gap_q     <= '0;
      frame_q   <= '0;
      err_cnt_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      retry_q   <= retry_d;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      frame_q   <= frame_d;
      err_cnt_q <= err_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_start  = (state_q == StIssue);
  assign busy      = (state_q != StIdle);
  assign wr_frame  = frame_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_codec_write_scheduler.sv
// Directed bench for codec_write_scheduler: reset, ACK/NACK/timeout paths, round-robin, gap timing.
module tb_codec_write_scheduler;

  localparam int unsigned NReq    = 2;
  localparam int unsigned Gap     = 8;
  localparam int unsigned Timeout = 16;

  logic              clk;
  logic              reset_n;
  logic [NReq-1:0]   req;
  logic [16*NReq-1:0] req_data;
  logic [NReq-1:0]   req_done;
  logic [NReq-1:0]   req_err;
  logic              wr_start;
  logic [23:0]       wr_frame;
  logic              wr_done;
  logic              wr_nack;
  logic              busy;
  logic [7:0]        err_count;

  int total = 0;
  int bad   = 0;

  codec_write_scheduler #(
    .N_REQ          (NReq),
    .DEV_ADDR       (8'h34),
    .MAX_RETRY      (3),
    .GAP_CYCLES     (Gap),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .req_done  (req_done),
    .req_err   (req_err),
    .wr_start  (wr_start),
    .wr_frame  (wr_frame),
    .wr_done   (wr_done),
    .wr_nack   (wr_nack),
    .busy      (busy),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (wr_start !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("wr_start_seen", {31'd0, wr_start}, 32'd1);
  endtask

  // Engine response: wr_done (with nack) pulsed `delay` cycles after the wr_start cycle.
  task automatic reply(input logic nack, input int delay);
    repeat (delay) tick();
    wr_done = 1'b1;
    wr_nack = nack;
    tick();
    wr_done = 1'b0;
    wr_nack = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int starts;
    int ndone;

    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    wr_done  = 1'b0;
    wr_nack  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset values, then reset asserted mid-WAIT
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_start", {31'd0, wr_start}, 32'd0);
    chk("rst_frame", {8'd0, wr_frame}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_done", {30'd0, req_done}, 32'd0);
    req           = 2'b01;
    req_data[15:0] = 16'h1234;
    wait_start(5, n);
    chk("t1_latency", n, 1);
    chk("t1_frame", {8'd0, wr_frame}, 32'h00341234);
    tick();
    chk("t1_wait_busy", {31'd0, busy}, 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t1_midrst_busy", {31'd0, busy}, 32'd0);
    chk("t1_midrst_start", {31'd0, wr_start}, 32'd0);
    chk("t1_midrst_frame", {8'd0, wr_frame}, 32'd0);
    chk("t1_midrst_done", {30'd0, req_done}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t1_post_start", {31'd0, wr_start}, 32'd1);
    chk("t1_post_frame", {8'd0, wr_frame}, 32'h00341234);
    reply(1'b0, 1);
    chk("t1_done", {30'd0, req_done}, 32'd1);
    chk("t1_err", {30'd0, req_err}, 32'd0);
    req    = 2'b00;
    starts = 0;
    for (int i = 0; i < Gap - 1; i++) begin
      tick();
      if (wr_start === 1'b1) starts++;
    end
    chk("t1_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_no_restart", starts, 0);

    // 2: single ACKed write, then back-to-back spacing for the same requester
    req            = 2'b01;
    req_data[15:0] = 16'h0C6A;
    wait_start(5, n);
    chk("t2_frame", {8'd0, wr_frame}, 32'h00340C6A);
    reply(1'b0, 3);
    chk("t2_done", {30'd0, req_done}, 32'd1);
    chk("t2_err", {30'd0, req_err}, 32'd0);
    wait_start(40, n);
    chk("t2_b2b_spacing", n, Gap + 1);
    reply(1'b0, 1);
    chk("t2_done2", {30'd0, req_done}, 32'd1);
    req = 2'b00;
    wait_idle(40);

    // 3: round-robin with both requesting, fresh pointer
    do_reset();
    req      = 2'b11;
    req_data = {16'h0202, 16'h0101};
    for (int i = 0; i < 4; i++) begin
      wait_start(40, n);
      chk("t3_frame", {8'd0, wr_frame}, (i % 2 == 1) ? 32'h00340202 : 32'h00340101);
      reply(1'b0, 1);
      chk("t3_done", {30'd0, req_done}, (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    req = 2'b00;
    wait_idle(40);

    // 4: NACK twice then ACK
    req            = 2'b01;
    req_data[15:0] = 16'h0F55;
    starts         = 0;
    for (int i = 0; i < 3; i++) begin
      wait_start(40, n);
      starts++;
      if (i > 0) chk("t4_retry_spacing", n, Gap);
      chk("t4_frame", {8'd0, wr_frame}, 32'h00340F55);
      reply((i < 2) ? 1'b1 : 1'b0, 1);
      chk("t4_done", {30'd0, req_done}, (i == 2) ? 32'd1 : 32'd0);
      chk("t4_err", {30'd0, req_err}, 32'd0);
    end
    chk("t4_starts", starts, 3);
    chk("t4_err_count", {24'd0, err_count}, 32'd0);
    req = 2'b00;
    wait_idle(40);

    // 5: persistent NACK exhausts retries; err_count saturates
    req              = 2'b10;
    req_data[31:16]  = 16'h0E00;
    for (int a = 0; a < 4; a++) begin
      wait_start(40, n);
      chk("t5_frame", {8'd0, wr_frame}, 32'h00340E00);
      reply(1'b1, 1);
      chk("t5_done", {30'd0, req_done}, (a == 3) ? 32'd2 : 32'd0);
      chk("t5_err", {30'd0, req_err}, (a == 3) ? 32'd2 : 32'd0);
    end
    chk("t5_err_count1", {24'd0, err_count}, 32'd1);
    ndone = 0;
    for (int k = 0; k < 254; k++) begin
      for (int a = 0; a < 4; a++) begin
        wait_start(40, n);
        reply(1'b1, 1);
      end
      if (req_done === 2'b10 && req_err === 2'b10) ndone++;
    end
    chk("t5_fail_pulses", ndone, 254);
    chk("t5_err_count255", {24'd0, err_count}, 32'd255);
    for (int a = 0; a < 4; a++) begin
      wait_start(40, n);
      reply(1'b1, 1);
    end
    chk("t5_err_256th", {30'd0, req_err}, 32'd2);
    chk("t5_err_count_sat", {24'd0, err_count}, 32'd255);
    req = 2'b00;
    wait_idle(40);

    // 6: engine silent -> timeout; late wr_done in GAP ignored
    do_reset();
    req            = 2'b01;
    req_data[15:0] = 16'h1357;
    wait_start(5, n);
    repeat (Timeout - 1) tick();
    chk("t6_done_early", {30'd0, req_done}, 32'd0);
    tick();
    chk("t6_done", {30'd0, req_done}, 32'd1);
    chk("t6_err", {30'd0, req_err}, 32'd1);
    chk("t6_err_count", {24'd0, err_count}, 32'd1);
    req     = 2'b00;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("t6_late_done", {30'd0, req_done}, 32'd0);
    chk("t6_late_err", {30'd0, req_err}, 32'd0);
    repeat (Gap - 2) tick();
    chk("t6_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("t6_no_start", {31'd0, wr_start}, 32'd0);
    chk("t6_err_count_kept", {24'd0, err_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
